// File: rtl/sum_pack_pkg.sv
// Shared helpers for the sum_pack element packer: count-field sizing and
// the zero-fill slot mask used to clear unused slots of a short vector.
package sum_pack_pkg;

  // Upper bound on N*DW that slot_mask can describe.
  localparam int unsigned MASK_MAX = 4096;

  function automatic int unsigned clog2p1(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Ones over the low count*dw bits, zero above; callers cast to N*DW.
  function automatic logic [MASK_MAX-1:0] slot_mask(input int unsigned count,
                                                    input int unsigned dw);
    logic [MASK_MAX-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_MAX; i++) begin
      m[i] = (i < count * dw);
    end
    return m;
  endfunction

endpackage

// File: rtl/sum_pack.sv
// Packs a stream of DW-bit elements into N-element vectors for the sum
// reducer; in_last flushes a short vector with unused slots zeroed.
module sum_pack
  import sum_pack_pkg::*;
#(
  parameter  int unsigned N  = 8,
  parameter  int unsigned DW = 16,
  localparam int unsigned CW = clog2p1(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*DW-1:0]   out_data,
  output logic [CW-1:0]     out_count
);

  localparam int unsigned W   = N * DW;
  localparam int unsigned WIW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIW-1:0] LAST_IDX = WIW'(N - 1);

  logic [W-1:0]   fill;
  logic [WIW-1:0] wr_idx;
  logic [W-1:0]   merged;
  logic [W-1:0]   packed_next;
  logic           accept;
  logic           complete;

  // Single output slot: it frees in the same cycle the consumer takes it.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign complete = (wr_idx == LAST_IDX) || in_last;

  always_comb begin
    merged = fill;
    merged[wr_idx * DW +: DW] = in_data;
  end

  assign packed_next = merged & W'(slot_mask(32'(wr_idx) + 32'd1, DW));

  always_ff @(posedge clk) begin
    if (rst) begin
      fill      <= '0;
      wr_idx    <= '0;
      out_data  <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // A completion in the same cycle as a consume overrides the clear above.
      if (accept) begin
        if (complete) begin
          out_data  <= packed_next;
          out_count <= CW'(wr_idx) + CW'(1);
          out_valid <= 1'b1;
          fill      <= '0;
          wr_idx    <= '0;
        end else begin
          fill   <= merged;
          wr_idx <= wr_idx + WIW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sum_pack.sv
// Scoreboard bench for sum_pack: expected vectors are built from the driven
// elements and compared whenever the DUT hands a vector to the consumer.
module tb_sum_pack;
  import sum_pack_pkg::*;

  localparam int unsigned N  = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned W  = N * DW;
  localparam int unsigned CW = clog2p1(N);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;

  typedef struct {
    logic [W-1:0] data;
    int unsigned  count;
  } vec_t;

  vec_t         sb[$];
  logic [W-1:0] m_buf;
  int unsigned  m_idx;
  int unsigned  tests;
  int unsigned  fails;
  int unsigned  n_vec;

  sum_pack #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_accept(input logic [DW-1:0] d, input logic last);
    vec_t v;
    m_buf[m_idx * DW +: DW] = d;
    if (m_idx == N - 1 || last) begin
      v.data  = m_buf & W'(slot_mask(m_idx + 1, DW));
      v.count = m_idx + 1;
      sb.push_back(v);
      m_buf = '0;
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endtask

  // Called just after a falling edge with inputs set for the next rising edge.
  task automatic step();
    vec_t v;
    #2;
    if (rst) begin
      sb.delete();
      m_buf = '0;
      m_idx = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", W'(sb.size()), W'(1));
        end else begin
          v = sb.pop_front();
          n_vec++;
          check("sb_data", out_data, v.data);
          check("sb_count", W'(out_count), W'(v.count));
        end
      end
      if (in_valid && in_ready) model_accept(in_data, in_last);
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    int unsigned  sum;
    logic [W-1:0] held;
    tests = 0; fails = 0; n_vec = 0;
    m_buf = '0; m_idx = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_valid", W'(out_valid), W'(0));
    check("rst_count", W'(out_count), W'(0));
    check("rst_data", out_data, W'(0));
    check("rst_ready", W'(in_ready), W'(1));

    // Full vector 1..8
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) send(DW'(k), 1'b0);
    check("t1_valid", W'(out_valid), W'(1));
    check("t1_data", out_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    check("t1_count", W'(out_count), W'(8));
    sum = 0;
    for (int i = 0; i < int'(N); i++) sum += int'(out_data[i * DW +: DW]);
    check("t1_sum", W'(sum), W'(36));
    step();

    // Back-to-back 1..16
    for (int k = 1; k <= 16; k++) begin
      in_valid = 1'b1; in_data = DW'(k);
      #1 check("t2_ready", W'(in_ready), W'(1));
      step();
    end
    in_valid = 1'b0;
    step();

    // Short flush
    send(16'hAAAA, 1'b0);
    send(16'h5555, 1'b1);
    check("t3_valid", W'(out_valid), W'(1));
    check("t3_count", W'(out_count), W'(2));
    check("t3_data", out_data, W'(32'h5555_AAAA));
    step();

    // Backpressure: idle in_last is ignored, then stall with in_valid high
    in_last = 1'b1;
    step();
    in_last = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) send(DW'(100 + k), 1'b0);
    check("t4_valid", W'(out_valid), W'(1));
    held = out_data;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_data = DW'(200);
      #1 check("t4_ready", W'(in_ready), W'(0));
      check("t4_hold", out_data, held);
      step();
    end
    in_valid = 1'b0; in_last = 1'b1;
    step();
    in_last = 1'b0;
    check("t4_hold_end", out_data, held);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) send(DW'(200 + k), 1'b0);
    held = out_data;
    check("t4_slot0", W'(held[DW-1:0]), W'(200));
    step();

    // Consume A while completing one-element B in the same cycle
    out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) send(DW'(16'h50 + k), 1'b0);
    out_ready = 1'b1;
    send(16'h00BB, 1'b1);
    check("t5_valid", W'(out_valid), W'(1));
    check("t5_data", out_data, W'(16'h00BB));
    check("t5_count", W'(out_count), W'(1));
    step();
    check("t5_drained", W'(out_valid), W'(0));

    // Reset mid-fill
    for (int k = 1; k <= 3; k++) send(DW'(k), 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("t6_valid", W'(out_valid), W'(0));
    check("t6_count", W'(out_count), W'(0));
    for (int k = 10; k <= 17; k++) send(DW'(k), 1'b0);
    check("t6_data", out_data, 128'h0011_0010_000F_000E_000D_000C_000B_000A);
    check("t6_count8", W'(out_count), W'(8));
    repeat (3) step();

    check("sb_left", W'(sb.size()), W'(0));
    check("n_vec", W'(n_vec), W'(9));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
